// File: rtl/row_hit_judge_if.sv
// Column-judge bus: scroll/light/key inputs toward the judge, verdict pulses and counters back.
// The judge connects through the slave modport; the driver of the column connects through master.
interface row_hit_judge_if #(
   parameter int SCORE_W = 8
);
   logic               is10;
   logic               lightOn;
   logic               key;
   logic               hit;
   logic               miss;
   logic               bad;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] combo;

   modport master (
      output is10, lightOn, key,
      input  hit, miss, bad, score, combo
   );

   modport slave (
      input  is10, lightOn, key,
      output hit, miss, bad, score, combo
   );
endinterface

// File: rtl/row_hit_judge.sv
// Per-column hit judge: one verdict (hit/miss/bad/none) per scroll period from lightOn and key,
// plus a saturating score and a combo count.
module row_hit_judge #(
   parameter int SCORE_W     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic           Clock,
   input  logic           Reset,
   row_hit_judge_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_ARMED,
      S_DONE
   } state_t;

   localparam logic [SCORE_W-1:0] ONE = SCORE_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   key_prev_q;
   logic                   press_q;

   state_t state_q, state_d;
   logic   hit_q, hit_d;
   logic   miss_q, miss_d;
   logic   bad_q, bad_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] combo_q, combo_d;

   // press is registered so a raw edge reaches the verdict SYNC_STAGES+2 cycles later
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync_q     <= '0;
         key_prev_q <= 1'b0;
         press_q    <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.key};
         key_prev_q <= sync_q[SYNC_STAGES-1];
         press_q    <= sync_q[SYNC_STAGES-1] & ~key_prev_q;
      end
   end

   always_comb begin
      state_d = state_q;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      bad_d   = 1'b0;
      if (bus.is10) begin
         state_d = S_LOAD;
         if (state_q == S_ARMED) begin
            if (press_q) hit_d  = 1'b1;
            else         miss_d = 1'b1;
         end
      end else begin
         case (state_q)
            S_LOAD:  state_d = bus.lightOn ? S_ARMED : S_IDLE;
            S_ARMED: begin
               if (press_q) begin
                  hit_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
            S_IDLE:  bad_d = press_q;
            default: ;
         endcase
      end
   end

   always_comb begin
      score_d = score_q;
      combo_d = combo_q;
      if (hit_q) begin
         if (score_q != '1) score_d = score_q + ONE;
         if (combo_q != '1) combo_d = combo_q + ONE;
      end else if (miss_q || bad_q) begin
         combo_d = '0;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
         bad_q   <= 1'b0;
         score_q <= '0;
         combo_q <= '0;
      end else begin
         state_q <= state_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         bad_q   <= bad_d;
         score_q <= score_d;
         combo_q <= combo_d;
      end
   end

   assign bus.hit   = hit_q;
   assign bus.miss  = miss_q;
   assign bus.bad   = bad_q;
   assign bus.score = score_q;
   assign bus.combo = combo_q;

endmodule

// File: tb/tb_row_hit_judge.sv
// Scoreboard bench for row_hit_judge: expected verdicts (kind + cycle) are queued as stimulus is
// driven and matched against every pulse the judge produces.
module tb_row_hit_judge;

   localparam int W      = 4;
   localparam int MAXV   = (1 << W) - 1;
   localparam int K_HIT  = 1;
   localparam int K_MISS = 2;
   localparam int K_BAD  = 3;

   typedef struct {
      int kind;
      int cyc;
   } exp_t;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   always #5 Clock = ~Clock;

   row_hit_judge_if #(.SCORE_W(W)) bus ();

   row_hit_judge #(
      .SCORE_W     (W),
      .SYNC_STAGES (2)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   int   exp_score = 0;
   int   exp_combo = 0;
   bit   pend_miss = 1'b0;
   int   st = 0;  // judge state as the bench expects it: 0 idle, 1 armed, 2 done

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(posedge Clock) begin : monitor
      int   kind;
      exp_t e;
      #1;
      if (bus.hit || bus.miss || bus.bad) begin
         chk("onehot", 32'(bus.hit) + 32'(bus.miss) + 32'(bus.bad), 1);
         kind = bus.hit ? K_HIT : (bus.miss ? K_MISS : K_BAD);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", kind, 0);
         end else begin
            e = sb.pop_front();
            chk("verdict_kind", kind, e.kind);
            chk("verdict_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic push(input int kind, input int c);
      sb.push_back('{kind, c});
      if (kind == K_HIT) begin
         exp_score = (exp_score == MAXV) ? MAXV : exp_score + 1;
         exp_combo = (exp_combo == MAXV) ? MAXV : exp_combo + 1;
      end else begin
         exp_combo = 0;
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic chk_cnt();
      chk("score", 32'(bus.score), exp_score);
      chk("combo", 32'(bus.combo), exp_combo);
   endtask

   // n consecutive scroll ticks; lightOn is presented in the LOAD cycle after the last one
   task automatic tick(input bit light, input int n);
      for (int i = 0; i < n; i++) begin
         if (pend_miss) begin
            push(K_MISS, cyc + 1);
            pend_miss = 1'b0;
         end
         bus.is10 = 1'b1;
         step(1);
      end
      bus.is10    = 1'b0;
      bus.lightOn = light;
      st          = light ? 1 : 0;
      pend_miss   = light;
   endtask

   task automatic press_key();
      int k;
      k       = cyc;
      bus.key = 1'b1;
      if (st == 1) begin
         push(K_HIT, k + 4);
         pend_miss = 1'b0;
         st        = 2;
      end else if (st == 0) begin
         push(K_BAD, k + 4);
      end
   endtask

   task automatic hit_period();
      tick(1'b1, 1);
      step(3);
      press_key();
      step(2);
      bus.key = 1'b0;
      step(8);
      chk_cnt();
   endtask

   task automatic quiet_period(input bit light);
      tick(light, 1);
      step(12);
      chk_cnt();
   endtask

   initial begin : main
      int k;
      bus.is10    = 1'b0;
      bus.lightOn = 1'b0;
      bus.key     = 1'b0;
      #2 Reset = 1'b0;
      step(3);
      Reset = 1'b1;
      step(2);
      chk("rst_hit", 32'(bus.hit), 0);
      chk("rst_miss", 32'(bus.miss), 0);
      chk("rst_bad", 32'(bus.bad), 0);
      chk_cnt();

      // before the first tick the judge is IDLE: a press is a false press
      press_key();
      step(2);
      bus.key = 1'b0;
      step(6);
      chk_cnt();

      // key held across a tick: one hit, no miss, then a fresh press hits the next note
      tick(1'b1, 1);
      step(3);
      press_key();
      step(10);
      tick(1'b1, 1);
      step(3);
      bus.key = 1'b0;
      step(4);
      press_key();
      step(2);
      bus.key = 1'b0;
      step(6);
      chk_cnt();

      // lit note left alone: miss lands in the LOAD cycle of the next period
      quiet_period(1'b1);
      tick(1'b0, 1);
      step(3);
      press_key();
      step(2);
      bus.key = 1'b0;
      step(6);
      chk_cnt();

      // second press after a hit is ignored
      tick(1'b1, 1);
      step(3);
      press_key();
      step(2);
      bus.key = 1'b0;
      step(3);
      press_key();
      step(2);
      bus.key = 1'b0;
      step(6);
      chk_cnt();

      hit_period();
      hit_period();

      // press coincides with the closing tick while armed: hit, not miss
      tick(1'b1, 1);
      step(10);
      k       = cyc;
      bus.key = 1'b1;
      push(K_HIT, k + 4);
      pend_miss = 1'b0;
      st        = 2;
      step(3);
      tick(1'b0, 1);
      step(2);
      bus.key = 1'b0;
      step(8);
      chk_cnt();

      // press lands in the LOAD cycle: dropped
      bus.key = 1'b1;
      step(2);
      tick(1'b0, 1);
      step(3);
      bus.key = 1'b0;
      step(6);
      chk_cnt();

      // back-to-back ticks: first closes an armed period with a miss, second yields nothing
      quiet_period(1'b1);
      tick(1'b1, 2);
      step(3);
      press_key();
      step(2);
      bus.key = 1'b0;
      step(6);
      chk_cnt();

      // asynchronous reset mid-period
      chk("sb_drained", sb.size(), 0);
      #2 Reset = 1'b0;
      #1;
      chk("arst_hit", 32'(bus.hit), 0);
      chk("arst_miss", 32'(bus.miss), 0);
      chk("arst_bad", 32'(bus.bad), 0);
      chk("arst_score", 32'(bus.score), 0);
      chk("arst_combo", 32'(bus.combo), 0);
      exp_score = 0;
      exp_combo = 0;
      pend_miss = 1'b0;
      st        = 0;
      step(2);
      Reset = 1'b1;
      step(2);
      press_key();
      step(2);
      bus.key = 1'b0;
      step(6);
      chk_cnt();

      // saturation at 2^W-1, then a miss clears combo only
      repeat (17) hit_period();
      chk("sat_score", 32'(bus.score), MAXV);
      chk("sat_combo", 32'(bus.combo), MAXV);
      quiet_period(1'b1);
      tick(1'b0, 1);
      step(8);
      chk_cnt();
      chk("post_miss_score", 32'(bus.score), MAXV);

      step(4);
      chk("sb_left", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/row_hit_judge.md
# row_hit_judge

Per-column hit judge at the bottom of the DDR note-scroll pipeline. It reads the `lightOn` state of the column's last light row once per scroll period and compares it against the player's button. For each period it produces exactly one verdict: hit, miss, false press, or nothing. It also keeps a saturating score and combo count for that column. One instance sits beside each bottom-row light module.

## Interface
- `SCORE_W`, default 8: width of `score` and `combo`; both saturate at 2^SCORE_W−1.
- `SYNC_STAGES`, default 2: flops in the `key` synchronizer chain; minimum 2.

Ports:
- `Clock` input 1: single system clock; all state updates on its rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `is10` input 1: scroll tick, one-cycle pulse. It is the same enable that advances the light rows.
- `lightOn` input 1: bottom-row light for this column. It changes only in the cycle after `is10`.
- `key` input 1: raw, asynchronous player button, active-high.
- `hit` output 1: one-cycle pulse, note hit.
- `miss` output 1: one-cycle pulse, lit note expired unpressed.
- `bad` output 1: one-cycle pulse, press with no note present.
- `score` output SCORE_W: total hits, saturating.
- `combo` output SCORE_W: consecutive hits, saturating; cleared by miss or bad.

## Operation
- **Key path.** `key` passes through SYNC_STAGES flops. A rising-edge detector on the synchronized value produces `press`, a one-cycle pulse.
- **State machine.** Four states:
  - IDLE: no note in the current period.
  - LOAD: sampling the new period.
  - ARMED: note present, not yet hit.
  - DONE: note already hit this period.
- **Transitions.** Evaluated in this priority order each cycle:
  - `is10`=1, any state: go to LOAD. If the state was ARMED and `press`=0, pulse `miss`. If the state was ARMED and `press`=1, pulse `hit` instead of `miss`.
  - LOAD: go to ARMED if `lightOn`=1, otherwise IDLE. A `press` in LOAD is dropped with no verdict.
  - ARMED with `press`: pulse `hit` and go to DONE.
  - IDLE with `press`: pulse `bad` and stay in IDLE.
  - DONE with `press`: ignored. No double count and no `bad`.
  - Otherwise: hold state.
- **Counters.** Both update in the same cycle as their pulse, so the new value is visible one cycle after the pulse.
  - `hit`: `score` +1 and `combo` +1, each saturating at 2^SCORE_W−1 with no wrap.
  - `miss` or `bad`: `combo` goes to 0; `score` is unchanged.
- At most one of `hit`/`miss`/`bad` is high in any cycle.
- **Reset** (asynchronous, active-low), effective immediately, mid-period included:
  - state goes to IDLE;
  - `hit`, `miss`, `bad` go to 0;
  - `score` and `combo` go to 0;
  - the synchronizer chain and edge-detect register go to 0.
  - After release, the block stays in IDLE until the first `is10`; presses before then produce `bad`.

## Timing
- Pulses, state and counters are all registered; there are no combinational outputs.
- A `key` rising edge reaches `press` SYNC_STAGES+1 cycles later. The verdict pulse appears 1 cycle after `press`, so a raw key edge gives a verdict SYNC_STAGES+2 cycles later (4 at the defaults).
- After an `is10` at cycle t: LOAD at t+1, and `lightOn` is sampled at t+1. The ARMED or IDLE window runs from t+2 through the next `is10`, inclusive.
- A `miss` pulse appears in the cycle after the closing `is10`, which is the same cycle as LOAD.
- Back-to-back `is10` pulses (period 1) are legal. The second tick overrides LOAD, so the state returns to LOAD and that period gets no verdict.
- A `key` held high produces exactly one `press`. A new press requires a release lasting at least one synchronized cycle.

## Test plan
- **Reset values.** Drive `Reset`=0 mid-run with `score`=5, `combo`=3. All outputs read 0 in the same cycle; after release, state is IDLE.
- **Hit.** `lightOn`=1 after `is10`; `key` rises 10 cycles later. `hit` pulses once, 4 cycles after the edge; `score` goes 0→1 and `combo` 0→1. Holding `key` through the next `is10` gives no second `hit` and no `miss`.
- **Miss.** `lightOn`=1 and no key for the whole period. `miss` pulses in the cycle after the next `is10`, and `combo` goes 3→0 with `score` unchanged.
- **False press.** `lightOn`=0 with a key press mid-period. `bad` pulses and `combo` goes to 0. A second press in DONE after a hit gives no pulse.
- **Simultaneous events.**
  - A `press` landing in the same cycle as `is10` while ARMED gives `hit` and no `miss`.
  - A `press` landing in the LOAD cycle gives no pulse.
- **Saturation.** With SCORE_W=4, 17 consecutive hits leave `score`=15 and `combo`=15; a following miss gives `combo`=0 and `score`=15.
